// File: rtl/interleave_chain_checker.sv
// Driver/checker for a cosimulated delay/inverter chain: launches edges,
// checks tap polarity, propagation order and stray toggles, records latency.
module interleave_chain_checker #(
    parameter int                STAGES      = 5,
    parameter logic [STAGES-1:0] INVERT_MASK = {STAGES{1'b1}},
    parameter int                SYNC        = 2,
    parameter int                TIMEOUT     = 16,
    parameter int                ROUNDS      = 8,
    parameter int                LATW        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [STAGES-1:0]            tap,
    output logic                         stim,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [$clog2(STAGES)-1:0]    err_stage,
    output logic [$clog2(ROUNDS+1)-1:0]  round_cnt,
    output logic [LATW-1:0]              last_latency
);

    localparam int SW = $clog2(STAGES);
    localparam int RW = $clog2(ROUNDS + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);
    localparam logic [RW-1:0] RMAX = RW'(ROUNDS);
    localparam logic [1:0] WARM = 2'(SYNC + 1);
    localparam logic [31:0] LAT_MAX = 32'((64'd1 << LATW) - 64'd1);

    localparam logic [1:0] C_ORDER = 2'd1;
    localparam logic [1:0] C_STRAY = 2'd2;
    localparam logic [1:0] C_TOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_d;
    logic stim_q, stim_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic [1:0] code_q, code_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [RW-1:0] round_q, round_d;
    logic [LATW-1:0] lat_q, lat_d;
    logic [STAGES-1:0] pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] warm_q, warm_d;
    logic [STAGES-1:0] tap_p_q;

    logic [STAGES-1:0] tap_s;
    logic [STAGES-1:0] exp_v;
    logic [STAGES-1:0] blk;
    logic [STAGES-1:0] tog;
    logic [STAGES-1:0] bad1;
    logic [STAGES-1:0] bad2;
    logic [STAGES-1:0] pend_clr;
    logic [CW-1:0] cnt_n;
    logic [RW-1:0] round_n;
    logic [LATW-1:0] lat_sat;
    logic fail;
    logic [1:0] fcode;
    logic [SW-1:0] fstage;

    if (SYNC == 0) begin : g_nosync
        assign tap_s = tap;
    end else begin : g_sync
        logic [STAGES-1:0] s1_q;
        logic [STAGES-1:0] s2_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q <= '0;
                s2_q <= '0;
            end else begin
                s1_q <= tap;
                s2_q <= s1_q;
            end
        end
        assign tap_s = s2_q;
    end

    function automatic logic [SW-1:0] lowest(input logic [STAGES-1:0] v);
        logic [SW-1:0] r;
        r = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (v[i]) r = SW'(i);
        end
        return r;
    endfunction

    // exp_v is the settled chain value; blk marks taps with a silent pending upstream
    always_comb begin
        logic p;
        logic b;
        exp_v = '0;
        blk = '0;
        p = stim_q;
        b = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            p = p ^ INVERT_MASK[i];
            exp_v[i] = p;
            blk[i] = b;
            b = b | (pend_q[i] & ~tog[i]);
        end
    end

    // Toggles are ignored until the sampling pipe holds real tap data after reset
    assign tog = (tap_s ^ tap_p_q) & {STAGES{warm_q == WARM}};
    assign bad2 = tog & (~pend_q | (tap_s ^ exp_v));
    assign bad1 = tog & blk;
    assign pend_clr = pend_q & ~tog;
    assign cnt_n = (cnt_q == TO) ? cnt_q : cnt_q + CW'(1);
    assign round_n = round_q + RW'(1);
    assign lat_sat = (32'(cnt_n) > LAT_MAX) ? '1 : LATW'(cnt_n);

    always_comb begin
        state_d = state_q;
        stim_d = stim_q;
        busy_d = busy_q;
        done_d = done_q;
        err_d = err_q;
        code_d = code_q;
        stage_d = stage_q;
        round_d = round_q;
        lat_d = lat_q;
        pend_d = pend_q;
        cnt_d = cnt_q;
        warm_d = (warm_q == WARM) ? warm_q : warm_q + 2'd1;
        fail = 1'b0;
        fcode = '0;
        fstage = '0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (|tog) begin
                    fail = 1'b1;
                    fcode = C_STRAY;
                    fstage = lowest(tog);
                end else if (start) begin
                    if (tap_s != exp_v) begin
                        fail = 1'b1;
                        fcode = C_TOUT;
                        fstage = lowest(tap_s ^ exp_v);
                    end else begin
                        round_d = '0;
                        done_d = 1'b0;
                        busy_d = 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (|tog) begin
                    fail = 1'b1;
                    fcode = C_STRAY;
                    fstage = lowest(tog);
                end else begin
                    stim_d = ~stim_q;
                    pend_d = '1;
                    cnt_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_n;
                if (|bad2) begin
                    fail = 1'b1;
                    fcode = C_STRAY;
                    fstage = lowest(bad2);
                end else if (|bad1) begin
                    fail = 1'b1;
                    fcode = C_ORDER;
                    fstage = lowest(bad1);
                end else begin
                    pend_d = pend_clr;
                    if (pend_clr == '0) begin
                        lat_d = lat_sat;
                        round_d = round_n;
                        if (round_n == RMAX) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LAUNCH;
                        end
                    end else if (cnt_n == TO) begin
                        fail = 1'b1;
                        fcode = C_TOUT;
                        fstage = lowest(pend_clr);
                    end
                end
            end
            default: begin
            end
        endcase
        if (fail) begin
            state_d = S_ERR;
            err_d = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b0;
            code_d = fcode;
            stage_d = fstage;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stim_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            code_q <= '0;
            stage_q <= '0;
            round_q <= '0;
            lat_q <= '0;
            pend_q <= '0;
            cnt_q <= '0;
            warm_q <= '0;
            tap_p_q <= '0;
        end else begin
            state_q <= state_d;
            stim_q <= stim_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            code_q <= code_d;
            stage_q <= stage_d;
            round_q <= round_d;
            lat_q <= lat_d;
            pend_q <= pend_d;
            cnt_q <= cnt_d;
            warm_q <= warm_d;
            tap_p_q <= tap_s;
        end
    end

    assign stim = stim_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign err_code = code_q;
    assign err_stage = stage_q;
    assign round_cnt = round_q;
    assign last_latency = lat_q;

endmodule

// File: doc/interleave_chain_checker.md
Name: interleave_chain_checker

Overview:
- Verilog-side driver and checker for a cosimulated delay/inverter chain of STAGES elements spanning Verilog and prsim.
- Toggles a launch signal, watches every chain tap return, and checks three properties: per-tap polarity, in-order propagation (no tap may fire before its upstream tap), and absence of stray toggles.
- Records the round-trip latency of each round and repeats for ROUNDS rounds.
- Replaces the free-running clock/monitor bench with a self-checking, parametrised block.

Parameters:
- STAGES, 5, number of chain taps observed (must be ≥2).
- INVERT_MASK, {STAGES{1'b1}}, bit i = 1 means stage i inverts its input; bit i = 0 means it buffers.
- SYNC, 2, synchroniser flops on the taps; legal values are 0 or 2.
- TIMEOUT, 16, maximum WAIT cycles per round (must be ≥ SYNC+2).
- ROUNDS, 8, launches per run (must be ≥1).
- LATW, 8, width of the latency counter/output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle run request.
- tap  in  STAGES  chain outputs coming back from prsim; asynchronous.
- stim  out  1  launch signal driven into chain input 0.
- busy  out  1  high while a run is in progress.
- done  out  1  level; high when a run completed with no error.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 0 none, 1 order, 2 stray/glitch, 3 timeout/init.
- err_stage  out  $clog2(STAGES)  lowest offending tap index.
- round_cnt  out  $clog2(ROUNDS+1)  rounds completed in the current run.
- last_latency  out  LATW  latency of the most recent completed round.

Behaviour:
- Reset: synchronous, active-low; rst_n low at any clk edge aborts everything.
  - All outputs go to 0: stim=0, busy=0, done=0, err=0, err_code=0, err_stage=0, round_cnt=0, last_latency=0.
  - State returns to IDLE; the synchroniser and previous-tap registers load 0.
- Tap sampling:
  - tap passes through SYNC flops to give tap_s; tap_p is tap_s delayed one cycle.
  - tog = tap_s ^ tap_p.
- Expected polarity:
  - exp[0] = stim ^ INVERT_MASK[0].
  - exp[i] = exp[i-1] ^ INVERT_MASK[i].
- States: IDLE, LAUNCH, WAIT, DONE, ERR.
- IDLE/DONE:
  - Any tog bit goes to ERR with code 2. An error takes priority over a start in the same cycle.
  - A start with tap_s != exp goes to ERR with code 3 (init mismatch).
  - Otherwise a start clears round_cnt and done, sets busy=1, and goes to LAUNCH.
- LAUNCH (1 cycle):
  - stim inverts, pending <= all ones, cnt <= 0, then go to WAIT.
  - Any tog in this cycle goes to ERR with code 2.
- WAIT, each cycle:
  - cnt increments.
  - Any tog[i] with pending[i]=0 goes to ERR code 2.
  - Else any tog[i] where some j<i has pending[j]=1 and tog[j]=0 goes to ERR code 1.
  - Taps that fire in the same cycle as their upstream are legal.
  - Valid toggles clear their pending bits.
  - A tap that toggles to a value != exp[i] is code 2.
- Round completion: when pending becomes 0, last_latency <= cnt and round_cnt increments.
  - If round_cnt reaches ROUNDS: busy=0, done=1, go to DONE.
  - Otherwise go to LAUNCH on the next cycle (back-to-back rounds).
- Latency definition: number of clk edges from the edge that toggles stim to the edge at which the final tap change appears in tog. A zero-delay loopback gives SYNC+1.
- Timeout: cnt == TIMEOUT with pending nonzero goes to ERR code 3, with err_stage = lowest pending index.
- Error reporting priority: code 2 > code 1 > code 3. err_stage is the lowest index for the winning code.
- ERR state: err=1, busy=0, stim holds its value. err, err_code and err_stage are sticky; start is ignored. Only rst_n low exits ERR.
- Counters: cnt saturates at TIMEOUT. last_latency saturates at 2^LATW-1.

Test Plan:
- Zero-delay loopback, STAGES=5, all stages inverting, SYNC=2, ROUNDS=8 → done=1 after 8 rounds, err=0, round_cnt=8, last_latency=3, stim toggled 8 times.
- Taps driven with per-stage delays of 1..5 cycles, SYNC=0 → each round last_latency=6, done=1, err=0.
- tap[3] fires two cycles before tap[2] → err=1, err_code=1, err_stage=3, busy=0, stim frozen.
- Extra pulse on tap[1] after it has already fired in round 2 → err_code=2, err_stage=1, round_cnt=1.
- tap[4] never toggles, TIMEOUT=16 → ERR 16 WAIT cycles after launch, err_code=3, err_stage=4; a later start is ignored; rst_n low for one edge clears all outputs to 0.
- INVERT_MASK=5'b00101 with a wrong-polarity idle tap, then start → err_code=3 with no stim toggle; start and a stray tap toggle in the same cycle → err_code=2.
